// File: rtl/stopwatch_core.sv
// Centisecond stopwatch (SS.cc, 00.00..59.99 with wrap) with run/pause/clear control.
// Four cascaded limited incrementers form the BCD digit chain fed by a tick prescaler.

module lim_inc #(
    parameter int W = 4,
    parameter int L = 10
) (
    input  logic [W-1:0] a,
    input  logic         ci,
    output logic [W-1:0] sum,
    output logic         co
);
    // Values at or above L-1 roll to 0 with carry, so a forced illegal value self-heals.
    always_comb begin
        co  = ci && (a >= W'(L - 1));
        sum = co ? '0 : a + {{(W-1){1'b0}}, ci};
    end
endmodule

// state  | meaning
// IDLE   | cleared, prescaler held at 0, digits at 00.00
// RUN    | prescaler counting, digits advance on each tick
// PAUSED | prescaler and digits frozen, resumes without losing the partial tick
module stopwatch_core #(
    parameter int TICK_DIV = 1000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] cs_ones,
    output logic [3:0] cs_tens,
    output logic [3:0] s_ones,
    output logic [2:0] s_tens,
    output logic       running,
    output logic       wrap
);
    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

    state_t        state, state_nx;
    logic          start_stop_q, clear_q;
    logic          ss_ev, clr_ev;
    logic [PW-1:0] presc, presc_nx;
    logic          tick;

    logic [3:0] cs_ones_nx, cs_tens_nx, s_ones_nx;
    logic [2:0] s_tens_nx;
    logic       c0, c1, c2, c3;

    assign ss_ev  = start_stop & ~start_stop_q;
    assign clr_ev = clear & ~clear_q;

    always_comb begin
        state_nx = state;
        presc_nx = presc;
        tick     = (state == RUN) && (presc == PW'(TICK_DIV - 1));

        case (state)
            RUN:     presc_nx = tick ? '0 : presc + PW'(1);
            PAUSED:  presc_nx = presc;
            default: presc_nx = '0;
        endcase

        if (ss_ev) begin
            case (state)
                IDLE:    state_nx = RUN;
                RUN:     state_nx = PAUSED;
                PAUSED:  state_nx = RUN;
                default: state_nx = IDLE;
            endcase
        end

        if (clr_ev) begin
            state_nx = IDLE;
            presc_nx = '0;
        end
    end

    lim_inc #(.W(4), .L(10)) u_cs_ones (.a(cs_ones), .ci(tick), .sum(cs_ones_nx), .co(c0));
    lim_inc #(.W(4), .L(10)) u_cs_tens (.a(cs_tens), .ci(c0),   .sum(cs_tens_nx), .co(c1));
    lim_inc #(.W(4), .L(10)) u_s_ones  (.a(s_ones),  .ci(c1),   .sum(s_ones_nx),  .co(c2));
    lim_inc #(.W(3), .L(6))  u_s_tens  (.a(s_tens),  .ci(c2),   .sum(s_tens_nx),  .co(c3));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            presc        <= '0;
            start_stop_q <= 1'b0;
            clear_q      <= 1'b0;
            running      <= 1'b0;
            wrap         <= 1'b0;
            cs_ones      <= '0;
            cs_tens      <= '0;
            s_ones       <= '0;
            s_tens       <= '0;
        end else begin
            state        <= state_nx;
            presc        <= presc_nx;
            start_stop_q <= start_stop;
            clear_q      <= clear;
            running      <= (state_nx == RUN);
            // Clear overrides a coincident tick, including the wrap pulse.
            wrap         <= c3 && !clr_ev;
            if (clr_ev) begin
                cs_ones <= '0;
                cs_tens <= '0;
                s_ones  <= '0;
                s_tens  <= '0;
            end else begin
                cs_ones <= cs_ones_nx;
                cs_tens <= cs_tens_nx;
                s_ones  <= s_ones_nx;
                s_tens  <= s_tens_nx;
            end
        end
    end
endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: directed scenarios plus random button traffic,
// checked every cycle against a centisecond-count reference model.
`timescale 1ns/1ps

module tb_stopwatch_core;
    localparam int TD = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] cs_ones, cs_tens, s_ones;
    logic [2:0] s_tens;
    logic       running, wrap;

    stopwatch_core #(.TICK_DIV(TD)) dut (
        .clk(clk), .reset_n(reset_n), .start_stop(start_stop), .clear(clear),
        .cs_ones(cs_ones), .cs_tens(cs_tens), .s_ones(s_ones), .s_tens(s_tens),
        .running(running), .wrap(wrap)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0, n_fail = 0;

    // Reference model: elapsed centiseconds plus the phase within the current tick.
    int m_mode = M_IDLE, m_total = 0, m_phase = 0;
    bit m_ss_q = 0, m_clr_q = 0, m_wrap = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_mode = M_IDLE; m_total = 0; m_phase = 0;
        m_ss_q = 0; m_clr_q = 0; m_wrap = 0;
    endfunction

    function automatic void model_step(input bit ss, input bit clr);
        bit ss_ev, clr_ev;
        ss_ev  = ss && !m_ss_q;
        clr_ev = clr && !m_clr_q;
        m_ss_q = ss;
        m_clr_q = clr;
        m_wrap = 0;
        if (clr_ev) begin
            m_mode = M_IDLE; m_total = 0; m_phase = 0;
        end else begin
            if (m_mode == M_RUN) begin
                if (m_phase == TD - 1) begin
                    m_phase = 0;
                    m_wrap  = (m_total == 5999);
                    m_total = (m_total + 1) % 6000;
                end else begin
                    m_phase++;
                end
            end
            if (ss_ev) m_mode = (m_mode == M_RUN) ? M_PAUSED : M_RUN;
        end
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".cs_ones"}, 32'(cs_ones), 32'(m_total % 10));
        chk({tag, ".cs_tens"}, 32'(cs_tens), 32'((m_total / 10) % 10));
        chk({tag, ".s_ones"},  32'(s_ones),  32'((m_total / 100) % 10));
        chk({tag, ".s_tens"},  32'(s_tens),  32'(m_total / 1000));
        chk({tag, ".running"}, 32'(running), 32'(m_mode == M_RUN));
        chk({tag, ".wrap"},    32'(wrap),    32'(m_wrap));
    endtask

    task automatic step(input bit ss, input bit clr);
        @(negedge clk);
        start_stop = ss;
        clear = clr;
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_step(ss, clr);
        #1;
        check_all("step");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard, n, frozen;

        // Reset and first start
        repeat (3) step(0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        step(0, 0);
        step(1, 0);
        chk("start_running", 32'(running), 32'd1);
        repeat (4) step(0, 0);
        chk("first_tick", 32'(cs_ones), 32'd1);
        repeat (4) step(0, 0);
        chk("second_tick", 32'(cs_ones), 32'd2);

        // Carry ripple 09.99 -> 10.00
        guard = 0;
        while (m_total != 999 && guard < 20000) begin step(0, 0); guard++; end
        chk("reach_0999", 32'(guard < 20000), 32'd1);
        repeat (TD) step(0, 0);
        chk("ripple_s_tens", 32'(s_tens), 32'd1);
        chk("ripple_low", 32'({s_ones, cs_tens, cs_ones}), 32'd0);
        chk("ripple_wrap", 32'(wrap), 32'd0);

        // Wrap 59.99 -> 00.00
        guard = 0;
        while (m_total != 5999 && guard < 30000) begin step(0, 0); guard++; end
        chk("reach_5999", 32'(guard < 30000), 32'd1);
        repeat (TD) step(0, 0);
        chk("wrap_pulse", 32'(wrap), 32'd1);
        chk("wrap_digits", 32'({s_tens, s_ones, cs_tens, cs_ones}), 32'd0);
        chk("wrap_running", 32'(running), 32'd1);
        step(0, 0);
        chk("wrap_one_cycle", 32'(wrap), 32'd0);

        // Pause with prescaler left at 2, resume, next increment after 2 RUN cycles
        guard = 0;
        while (m_phase != 1 && guard < 10) begin step(0, 0); guard++; end
        step(1, 0);
        chk("paused", 32'(running), 32'd0);
        frozen = m_total;
        repeat (20) begin
            step(0, 0);
            chk("pause_frozen", 32'(cs_ones), 32'(frozen % 10));
        end
        step(1, 0);
        n = 0;
        guard = 0;
        while (cs_ones == 4'(frozen % 10) && guard < 10) begin step(0, 0); n++; guard++; end
        chk("resume_latency", 32'(n), 32'd2);

        // Held button gives exactly one transition
        step(0, 1);
        step(0, 0);
        chk("cleared_idle", 32'(running), 32'd0);
        repeat (10) step(1, 0);
        chk("held_running", 32'(running), 32'd1);
        step(0, 0);

        // Simultaneous clear and start_stop in RUN
        step(1, 1);
        chk("simul_running", 32'(running), 32'd0);
        chk("simul_digits", 32'({s_tens, s_ones, cs_tens, cs_ones}), 32'd0);
        step(0, 0);
        step(0, 0);
        chk("simul_stays_idle", 32'(running), 32'd0);

        // Random button traffic
        repeat (3000) step(($urandom_range(0, 29) == 0), ($urandom_range(0, 299) == 0));

        // Asynchronous reset at 12.34
        step(0, 0);
        step(0, 1);
        step(0, 0);
        step(1, 0);
        guard = 0;
        while (m_total != 1234 && guard < 6000) begin step(0, 0); guard++; end
        chk("reach_1234", 32'({s_tens, s_ones, cs_tens, cs_ones}), 32'h1234);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        repeat (2) step(0, 0);
        #3;
        reset_n = 1'b1;
        repeat (10) step(0, 0);
        chk("post_rst_idle", 32'({running, s_tens, s_ones, cs_tens, cs_ones}), 32'd0);
        step(1, 0);
        repeat (8) step(0, 0);
        chk("post_rst_count", 32'(cs_ones), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
